// File: rtl/store_buffer.sv
// store_buffer: write-back store buffer between the pipeline and data memory.
//   Pending stores sit in a DEPTH-entry circular FIFO and drain to memory one
//   per cycle whenever the memory port is not taken by a clean load. Loads
//   are checked against the pending entries. If the youngest overlapping
//   entry covers the whole load, the data is forwarded. A partial overlap
//   stalls the load. A load with no overlap goes straight to memory.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   st_req/addr/data/mode  store request (mode 1 = byte, 2 = word)
//   st_ready               an entry is free
//   ld_req/addr/mode       load request (same mode encoding)
//   ld_data, ld_stall      load result / load cannot complete this cycle
//   empty                  no store pending
//   mem_*                  data-memory port (write commits on falling edge)
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        st_req,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   input  logic [2:0]  st_mode,
   output logic        st_ready,
   input  logic        ld_req,
   input  logic [31:0] ld_addr,
   input  logic [2:0]  ld_mode,
   output logic [31:0] ld_data,
   output logic        ld_stall,
   output logic        empty,
   output logic        mem_write,
   output logic        mem_read,
   output logic [31:0] mem_address,
   output logic [31:0] mem_writeData,
   output logic [2:0]  mem_mode,
   input  logic [31:0] mem_readData
);

   localparam int          PW      = $clog2(DEPTH);
   localparam int          CW      = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [2:0]  MODE_B  = 3'd1;
   localparam logic [2:0]  MODE_W  = 3'd2;

   logic [31:0]   e_addr [DEPTH];
   logic [31:0]   e_data [DEPTH];
   logic [2:0]    e_mode [DEPTH];
   logic [PW-1:0] head, tail;
   logic [CW-1:0] count;

   logic          push, drain, ld_act;
   logic          hit, hit_full;
   logic [31:0]   hit_data, hit_diff;
   logic [31:0]   ld_size, e_size, d_le, d_el, shifted;
   logic [PW-1:0] idx;

   assign st_ready = !reset && (count < DEPTH_C);
   assign empty    = (count == '0);
   assign push     = st_req && st_ready && (st_mode == MODE_B || st_mode == MODE_W);
   assign ld_act   = ld_req && (ld_mode == MODE_B || ld_mode == MODE_W);

   // Scan from oldest to youngest so the last hit written is the youngest.
   // Differences are taken mod 2^32, so ranges that wrap past address 0
   // are still compared correctly.
   always_comb begin
      hit      = 1'b0;
      hit_full = 1'b0;
      hit_data = '0;
      hit_diff = '0;
      idx      = '0;
      e_size   = '0;
      d_le     = '0;
      d_el     = '0;
      ld_size  = (ld_mode == MODE_W) ? 32'd4 : 32'd1;
      for (int i = 0; i < DEPTH; i++) begin
         idx    = head + PW'(i);
         e_size = (e_mode[idx] == MODE_W) ? 32'd4 : 32'd1;
         d_le   = ld_addr - e_addr[idx];
         d_el   = e_addr[idx] - ld_addr;
         if ((CW'(i) < count) && ((d_le < e_size) || (d_el < ld_size))) begin
            hit      = 1'b1;
            hit_full = (ld_size <= e_size) && (d_le <= e_size - ld_size);
            hit_data = e_data[idx];
            hit_diff = d_le;
         end
      end
   end

   // Byte lane selected by the load's offset into the entry (little-endian).
   assign shifted = hit_data >> {hit_diff[1:0], 3'b000};

   always_comb begin
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_address   = '0;
      mem_writeData = '0;
      mem_mode      = '0;
      ld_data       = '0;
      ld_stall      = 1'b0;
      drain         = 1'b0;
      if (!reset) begin
         if (ld_act && !hit) begin
            // Clean load owns the memory port this cycle.
            mem_read    = 1'b1;
            mem_address = ld_addr;
            mem_mode    = ld_mode;
            ld_data     = mem_readData;
         end else begin
            if (ld_act) begin
               if (hit_full)
                  ld_data = (ld_mode == MODE_W) ? hit_data
                                                : {{24{shifted[7]}}, shifted[7:0]};
               else
                  ld_stall = 1'b1;
            end
            if (count != '0) begin
               drain         = 1'b1;
               mem_write     = 1'b1;
               mem_address   = e_addr[head];
               mem_writeData = e_data[head];
               mem_mode      = e_mode[head];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push)  tail <= tail + PW'(1);
         if (drain) head <= head + PW'(1);
         if (push && !drain)
            count <= count + CW'(1);
         else if (drain && !push)
            count <= count - CW'(1);
      end
   end

   // Entry payload needs no reset; count alone says which slots are live.
   always_ff @(posedge clk) begin
      if (push) begin
         e_addr[tail] <= st_addr;
         e_data[tail] <= st_data;
         e_mode[tail] <= st_mode;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: self-checking bench for store_buffer. It uses a queue-based
// reference model that checks overlap byte by byte. Directed scenarios run
// first, followed by a randomized run that compares every output each cycle.
module tb_store_buffer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        st_req;
   logic [31:0] st_addr, st_data;
   logic [2:0]  st_mode;
   logic        st_ready;
   logic        ld_req;
   logic [31:0] ld_addr;
   logic [2:0]  ld_mode;
   logic [31:0] ld_data;
   logic        ld_stall, empty;
   logic        mem_write, mem_read;
   logic [31:0] mem_address, mem_writeData, mem_readData;
   logic [2:0]  mem_mode;

   int vec  = 0;
   int errs = 0;

   always #5 clk = ~clk;

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_mode(st_mode),
      .st_ready(st_ready),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_mode(ld_mode),
      .ld_data(ld_data), .ld_stall(ld_stall), .empty(empty),
      .mem_write(mem_write), .mem_read(mem_read), .mem_address(mem_address),
      .mem_writeData(mem_writeData), .mem_mode(mem_mode), .mem_readData(mem_readData)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  mode;
   } ent_t;

   typedef struct packed {
      logic        st_ready;
      logic        empty;
      logic        ld_stall;
      logic        mem_read;
      logic        mem_write;
      logic [31:0] ld_data;
      logic [31:0] mem_address;
      logic [31:0] mem_writeData;
      logic [2:0]  mem_mode;
   } exp_t;

   ent_t sb_q[$];   // pending stores, oldest at index 0

   // Reference: treat every access as a set of byte addresses. Find the
   // youngest store sharing a byte with the load. Forward only if every
   // load byte is found inside that store.
   function automatic exp_t model_out(input logic rst, input logic lr,
                                      input logic [31:0] la, input logic [2:0] lm,
                                      input logic [31:0] rd);
      exp_t        e;
      int          yi, ls, es;
      bit          full, found, act;
      logic [31:0] fw, ba, bb;
      ent_t        en;
      e = '0;
      e.empty = (sb_q.size() == 0);
      if (rst) return e;
      e.st_ready = (sb_q.size() < DEPTH);
      act = lr && (lm == 3'd1 || lm == 3'd2);
      ls  = (lm == 3'd2) ? 4 : 1;
      yi  = -1;
      if (act)
         for (int i = sb_q.size() - 1; i >= 0 && yi < 0; i--) begin
            es = (sb_q[i].mode == 3'd2) ? 4 : 1;
            for (int k = 0; k < ls; k++)
               for (int j = 0; j < es; j++) begin
                  ba = la + 32'(k);
                  bb = sb_q[i].addr + 32'(j);
                  if (ba == bb) yi = i;
               end
         end
      if (act && yi < 0) begin
         e.mem_read    = 1'b1;
         e.mem_address = la;
         e.mem_mode    = lm;
         e.ld_data     = rd;
         return e;
      end
      if (yi >= 0) begin
         en   = sb_q[yi];
         es   = (en.mode == 3'd2) ? 4 : 1;
         full = 1'b1;
         fw   = '0;
         for (int k = 0; k < ls; k++) begin
            found = 1'b0;
            for (int j = 0; j < es; j++) begin
               ba = la + 32'(k);
               bb = en.addr + 32'(j);
               if (ba == bb) begin
                  found = 1'b1;
                  fw[8*k +: 8] = en.data[8*j +: 8];
               end
            end
            if (!found) full = 1'b0;
         end
         if (!full) e.ld_stall = 1'b1;
         else       e.ld_data  = (lm == 3'd2) ? fw : {{24{fw[7]}}, fw[7:0]};
      end
      if (sb_q.size() > 0) begin
         e.mem_write     = 1'b1;
         e.mem_address   = sb_q[0].addr;
         e.mem_writeData = sb_q[0].data;
         e.mem_mode      = sb_q[0].mode;
      end
      return e;
   endfunction

   task automatic set_in(input logic sr, input logic [31:0] sa, input logic [31:0] sd,
                         input logic [2:0] sm, input logic lr, input logic [31:0] la,
                         input logic [2:0] lm, input logic [31:0] rd);
      st_req = sr; st_addr = sa; st_data = sd; st_mode = sm;
      ld_req = lr; ld_addr = la; ld_mode = lm; mem_readData = rd;
      #1;
   endtask

   task automatic idle();
      set_in(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0, 3'd0, 32'h0);
   endtask

   // Advance one rising edge and keep the reference queue in step.
   task automatic tick();
      exp_t e;
      bit   psh;
      ent_t n;
      e   = model_out(reset, ld_req, ld_addr, ld_mode, mem_readData);
      psh = !reset && st_req && (sb_q.size() < DEPTH) && (st_mode == 3'd1 || st_mode == 3'd2);
      n.addr = st_addr; n.data = st_data; n.mode = st_mode;
      @(posedge clk);
      if (reset) sb_q.delete();
      else begin
         if (e.mem_write && sb_q.size() > 0) void'(sb_q.pop_front());
         if (psh) sb_q.push_back(n);
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      set_in(1'b1, 32'h40, 32'h1234, 3'd2, 1'b1, 32'h80, 3'd2, 32'hDEADBEEF);
      vec++; if (st_ready !== 1'b0) begin errs++; $display("FAIL rst_st_ready: got %0b want 0", st_ready); end
      vec++; if (mem_read !== 1'b0) begin errs++; $display("FAIL rst_mem_read: got %0b want 0", mem_read); end
      vec++; if (mem_write !== 1'b0) begin errs++; $display("FAIL rst_mem_write: got %0b want 0", mem_write); end
      vec++; if (ld_data !== 32'h0) begin errs++; $display("FAIL rst_ld_data: got %h want 0", ld_data); end
      vec++; if (ld_stall !== 1'b0) begin errs++; $display("FAIL rst_ld_stall: got %0b want 0", ld_stall); end
      tick(); tick();
      reset = 1'b0;
      idle();
      vec++; if (empty !== 1'b1) begin errs++; $display("FAIL rst_empty: got %0b want 1", empty); end
      vec++; if (st_ready !== 1'b1) begin errs++; $display("FAIL rst_ready_after: got %0b want 1", st_ready); end
      vec++; if (mem_address !== 32'h0) begin errs++; $display("FAIL idle_addr: got %h want 0", mem_address); end
   endtask

   task automatic test_drain();
      set_in(1'b1, 32'h100, 32'h11223344, 3'd2, 1'b0, 32'h0, 3'd0, 32'h0);
      tick();
      idle();
      vec++; if (mem_write !== 1'b1) begin errs++; $display("FAIL drain_write: got %0b want 1", mem_write); end
      vec++; if (mem_address !== 32'h100) begin errs++; $display("FAIL drain_addr: got %h want 00000100", mem_address); end
      vec++; if (mem_mode !== 3'd2) begin errs++; $display("FAIL drain_mode: got %0d want 2", mem_mode); end
      vec++; if (mem_writeData !== 32'h11223344) begin errs++; $display("FAIL drain_data: got %h want 11223344", mem_writeData); end
      vec++; if (empty !== 1'b0) begin errs++; $display("FAIL drain_notempty: got %0b want 0", empty); end
      tick();
      idle();
      vec++; if (empty !== 1'b1) begin errs++; $display("FAIL drain_empty: got %0b want 1", empty); end
      vec++; if (mem_write !== 1'b0) begin errs++; $display("FAIL drain_idle: got %0b want 0", mem_write); end
   endtask

   task automatic test_forward_byte();
      set_in(1'b1, 32'h200, 32'h11223380, 3'd2, 1'b0, 32'h0, 3'd0, 32'h0);
      tick();
      set_in(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 32'h200, 3'd1, 32'h55555555);
      vec++; if (ld_data !== 32'hFFFFFF80) begin errs++; $display("FAIL fwd_byte_data: got %h want FFFFFF80", ld_data); end
      vec++; if (ld_stall !== 1'b0) begin errs++; $display("FAIL fwd_byte_stall: got %0b want 0", ld_stall); end
      vec++; if (mem_read !== 1'b0) begin errs++; $display("FAIL fwd_byte_read: got %0b want 0", mem_read); end
      vec++; if (mem_write !== 1'b1 || mem_address !== 32'h200) begin errs++; $display("FAIL fwd_byte_drain: got w=%0b a=%h want w=1 a=00000200", mem_write, mem_address); end
      tick();
      idle();
      vec++; if (empty !== 1'b1) begin errs++; $display("FAIL fwd_byte_empty: got %0b want 1", empty); end
   endtask

   task automatic test_partial_stall();
      set_in(1'b1, 32'h301, 32'h0000007F, 3'd1, 1'b0, 32'h0, 3'd0, 32'h0);
      tick();
      set_in(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 32'h300, 3'd2, 32'h12347F56);
      vec++; if (ld_stall !== 1'b1) begin errs++; $display("FAIL part_stall: got %0b want 1", ld_stall); end
      vec++; if (ld_data !== 32'h0 || mem_read !== 1'b0) begin errs++; $display("FAIL part_stall_out: got d=%h r=%0b want d=0 r=0", ld_data, mem_read); end
      vec++; if (mem_write !== 1'b1 || mem_address !== 32'h301 || mem_mode !== 3'd1) begin errs++; $display("FAIL part_drain: got w=%0b a=%h m=%0d want w=1 a=00000301 m=1", mem_write, mem_address, mem_mode); end
      tick();
      vec++; if (ld_stall !== 1'b0 || mem_read !== 1'b1) begin errs++; $display("FAIL part_clean: got s=%0b r=%0b want s=0 r=1", ld_stall, mem_read); end
      vec++; if (ld_data !== 32'h12347F56) begin errs++; $display("FAIL part_clean_data: got %h want 12347F56", ld_data); end
      vec++; if (mem_address !== 32'h300 || mem_mode !== 3'd2 || mem_write !== 1'b0) begin errs++; $display("FAIL part_clean_port: got a=%h m=%0d w=%0b want a=00000300 m=2 w=0", mem_address, mem_mode, mem_write); end
      tick();
      idle();
   endtask

   task automatic test_full();
      for (int k = 0; k < 4; k++) begin
         set_in(1'b1, 32'h500 + 32'(4*k), 32'hC0DE0000 + 32'(k), 3'd2, 1'b1, 32'h8000, 3'd2, 32'h0BADF00D);
         vec++; if (mem_write !== 1'b0 || mem_read !== 1'b1) begin errs++; $display("FAIL full_hold%0d: got w=%0b r=%0b want w=0 r=1", k, mem_write, mem_read); end
         tick();
      end
      set_in(1'b1, 32'h510, 32'hFFFF0000, 3'd2, 1'b1, 32'h8000, 3'd2, 32'h0BADF00D);
      vec++; if (st_ready !== 1'b0) begin errs++; $display("FAIL full_ready: got %0b want 0", st_ready); end
      tick();
      idle();
      vec++; if (st_ready !== 1'b0 || empty !== 1'b0) begin errs++; $display("FAIL full_after5: got rdy=%0b e=%0b want 0 0", st_ready, empty); end
      for (int k = 0; k < 4; k++) begin
         vec++; if (mem_write !== 1'b1 || mem_address !== 32'h500 + 32'(4*k) || mem_writeData !== 32'hC0DE0000 + 32'(k)) begin
            errs++; $display("FAIL full_order%0d: got w=%0b a=%h d=%h", k, mem_write, mem_address, mem_writeData); end
         tick();
         idle();
      end
      vec++; if (empty !== 1'b1 || mem_write !== 1'b0) begin errs++; $display("FAIL full_empty: got e=%0b w=%0b want 1 0", empty, mem_write); end
   endtask

   task automatic test_youngest();
      set_in(1'b1, 32'h400, 32'hAAAA0000, 3'd2, 1'b1, 32'h9000, 3'd2, 32'h0);
      tick();
      set_in(1'b1, 32'h400, 32'hBBBB0000, 3'd2, 1'b1, 32'h9000, 3'd2, 32'h0);
      tick();
      set_in(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 32'h400, 3'd2, 32'h77777777);
      vec++; if (ld_data !== 32'hBBBB0000 || ld_stall !== 1'b0) begin errs++; $display("FAIL young_fwd: got d=%h s=%0b want BBBB0000 0", ld_data, ld_stall); end
      vec++; if (mem_writeData !== 32'hAAAA0000) begin errs++; $display("FAIL young_drain: got %h want AAAA0000", mem_writeData); end
      tick();
      idle();
      tick();
      idle();
      vec++; if (empty !== 1'b1) begin errs++; $display("FAIL young_empty: got %0b want 1", empty); end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 3; k++) begin
         set_in(1'b1, 32'h600 + 32'(4*k), 32'h600D0000 + 32'(k), 3'd2, 1'b1, 32'h9000, 3'd2, 32'h0);
         tick();
      end
      reset = 1'b1;
      idle();
      vec++; if (mem_write !== 1'b0 || st_ready !== 1'b0) begin errs++; $display("FAIL rmid_forced: got w=%0b rdy=%0b want 0 0", mem_write, st_ready); end
      tick();
      reset = 1'b0;
      idle();
      for (int k = 0; k < 2; k++) begin
         vec++; if (empty !== 1'b1 || mem_write !== 1'b0) begin errs++; $display("FAIL rmid_dropped%0d: got e=%0b w=%0b want 1 0", k, empty, mem_write); end
         tick();
         idle();
      end
   endtask

   task automatic test_random();
      exp_t e;
      logic [2:0] sm, lm;
      for (int n = 0; n < 600; n++) begin
         reset = ($urandom_range(0, 63) == 0);
         sm = 3'($urandom_range(0, 5)); if (sm > 3'd3) sm = sm - 3'd3;
         lm = 3'($urandom_range(0, 5)); if (lm > 3'd3) lm = lm - 3'd3;
         set_in(1'($urandom_range(0, 1)), 32'hFFFFFFF8 + 32'($urandom_range(0, 15)), $urandom, sm,
                ($urandom_range(0, 3) != 0), 32'hFFFFFFF8 + 32'($urandom_range(0, 15)), lm, $urandom);
         e = model_out(reset, ld_req, ld_addr, ld_mode, mem_readData);
         vec++; if (st_ready !== e.st_ready) begin errs++; $display("FAIL rnd%0d st_ready: got %0b want %0b", n, st_ready, e.st_ready); end
         vec++; if (empty !== e.empty) begin errs++; $display("FAIL rnd%0d empty: got %0b want %0b", n, empty, e.empty); end
         vec++; if (ld_stall !== e.ld_stall) begin errs++; $display("FAIL rnd%0d ld_stall: got %0b want %0b", n, ld_stall, e.ld_stall); end
         vec++; if (ld_data !== e.ld_data) begin errs++; $display("FAIL rnd%0d ld_data: got %h want %h", n, ld_data, e.ld_data); end
         vec++; if (mem_read !== e.mem_read) begin errs++; $display("FAIL rnd%0d mem_read: got %0b want %0b", n, mem_read, e.mem_read); end
         vec++; if (mem_write !== e.mem_write) begin errs++; $display("FAIL rnd%0d mem_write: got %0b want %0b", n, mem_write, e.mem_write); end
         vec++; if (mem_address !== e.mem_address) begin errs++; $display("FAIL rnd%0d mem_address: got %h want %h", n, mem_address, e.mem_address); end
         vec++; if (mem_writeData !== e.mem_writeData) begin errs++; $display("FAIL rnd%0d mem_writeData: got %h want %h", n, mem_writeData, e.mem_writeData); end
         vec++; if (mem_mode !== e.mem_mode) begin errs++; $display("FAIL rnd%0d mem_mode: got %0d want %0d", n, mem_mode, e.mem_mode); end
         tick();
      end
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_drain();
      test_forward_byte();
      test_partial_stall();
      test_full();
      test_youngest();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, number of pending store entries, a power of two and at least 2.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, synchronous, active-high.
REQ-004 The block SHALL have port st_req, input, 1 bit, store request from the pipeline.
REQ-005 The block SHALL have ports st_addr (input, 32 bits, byte address), st_data (input, 32 bits) and st_mode (input, 3 bits: 1 = byte, 2 = word).
REQ-006 The block SHALL have port st_ready, output, 1 bit, high when an entry is free.
REQ-007 The block SHALL have ports ld_req (input, 1 bit), ld_addr (input, 32 bits) and ld_mode (input, 3 bits, same encoding as st_mode), the load request.
REQ-008 The block SHALL have ports ld_data (output, 32 bits, load result) and ld_stall (output, 1 bit, load cannot complete this cycle).
REQ-009 The block SHALL have port empty, output, 1 bit, high when no store is pending.
REQ-010 The block SHALL have data-memory-side ports mem_write (output, 1), mem_read (output, 1), mem_address (output, 32), mem_writeData (output, 32), mem_mode (output, 3) and mem_readData (input, 32).

Function
REQ-011 Storage: circular FIFO of DEPTH entries {addr, data, mode}, with head/tail pointers and a count.
REQ-012 Push: at the rising edge with st_req=1, st_ready=1 and st_mode in {1,2}, the block SHALL enqueue the store at the tail.
REQ-013 Ignored stores: a store with st_mode not in {1,2}, or presented while st_ready=0, SHALL be ignored with no state change.
REQ-014 st_ready SHALL equal (count < DEPTH); a pop in the same cycle SHALL NOT raise st_ready.
REQ-015 Overlap: an entry covers bytes [addr, addr+size), size 1 for byte and 4 for word; a load likewise.
- A load overlaps an entry when those ranges intersect.
- Comparison SHALL use 32-bit wrap-around arithmetic.
REQ-016 Load classification: when ld_req=1 and ld_mode is in {1,2}, the youngest overlapping entry decides the outcome.
- No overlap: clean load.
- Youngest overlap fully contains the load range: forward.
- Any other overlap: stall.
REQ-017 Clean load: same cycle, combinationally, the block SHALL drive mem_read=1, mem_write=0, mem_address=ld_addr, mem_mode=ld_mode, and ld_data=mem_readData, with ld_stall=0.
REQ-018 Forward: ld_data SHALL be taken from the entry, ld_stall=0, and mem_read=0.
- Word load from a word entry: entry data.
- Byte load: entry byte at offset (ld_addr - entry.addr), little-endian, sign-extended to 32 bits.
REQ-019 Stall: ld_stall=1, ld_data=0, mem_read=0.
REQ-020 Drain: mem_write=1, driving the head entry on mem_address, mem_writeData and mem_mode (data memory commits on the falling edge).
- Drain occurs when count>0 and the cycle is not a clean load.
- Drain occurs during forwarded and stalled loads.
- The head SHALL pop at the next rising edge.
REQ-021 Memory port priority: clean load > drain; mem_read and mem_write SHALL never both be 1.
REQ-022 Simultaneous push and pop: count SHALL be unchanged, and both pointers SHALL advance modulo DEPTH.
REQ-023 Invalid load mode or ld_req=0: ld_data=0 and ld_stall=0; drain proceeds if count>0.
REQ-024 Idle: when no memory operation is driven, mem_address, mem_writeData and mem_mode SHALL be 0.
REQ-025 empty SHALL equal (count == 0).
REQ-026 A push SHALL NOT be visible to the load compare until the cycle after its enqueue edge.

Reset
REQ-027 At a rising edge with reset=1, the block SHALL clear count, head and tail to 0 and drop all pending stores, including mid-drain.
REQ-028 While reset=1, the block SHALL force st_ready=0, mem_write=0, mem_read=0, ld_stall=0 and ld_data=0, and empty=1 after the edge.

Verification
REQ-029 Push word 0x11223344 to 0x100, then hold ld_req=0 -> mem_write=1, mem_address=0x100, mem_mode=2 the next cycle; empty=1 after one further edge.
REQ-030 Push word 0x11223380 to 0x200; next cycle byte load at 0x200 -> ld_data=0xFFFFFF80, ld_stall=0, mem_read=0, drain proceeds.
REQ-031 Push byte 0x7F to 0x301; next cycle word load at 0x300 -> ld_stall=1 until the entry drains, then a clean load returns mem_readData with byte1=0x7F.
REQ-032 With DEPTH=4, push 4 stores while a clean load is held every cycle -> st_ready=0, a fifth st_req is ignored, count stays 4; dropping ld_req drains in FIFO order.
REQ-033 Two word stores to 0x400 (0xAAAA0000, then 0xBBBB0000), then word load at 0x400 -> forwards 0xBBBB0000 (youngest).
REQ-034 Three stores pending, reset asserted for one edge -> empty=1, mem_write=0, and none of the pending stores are written.
